cdb_arbiter: RTL and testbench
==============================

CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 6, number of completing functional-unit requesters (NUM_FU >= `N).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, wait cycles before a requester is forced (used only with CDB_STARVE_GUARD_EN).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fu_valid  input  NUM_FU  per-FU completion request.
REQ-006 SHALL have port fu_tag  input  NUM_FU x PHYS_REG_IDX_BIG  destination physical register per FU.
REQ-007 SHALL have port squash  input  1  pipeline flush; discards in-flight broadcasts.
REQ-008 SHALL have port fu_ready  output  NUM_FU  combinational grant; handshake completes when fu_valid & fu_ready.
REQ-009 SHALL have port cdb_tags  output  `N x PHYS_REG_IDX_BIG  registered broadcast tags feeding the complete list's inputs_completing.
REQ-010 SHALL have port cdb_valid  output  `N  registered per-lane valid.

Function
REQ-011 SHALL grant at most `N requesters per cycle; fu_ready is high only for granted FUs.
REQ-012 SHALL select grants by round-robin search starting at pointer rr_ptr, wrapping NUM_FU-1 -> 0.
REQ-013 SHALL assign grants to lanes 0..`N-1 in search order; unused lanes carry no grant.
REQ-014 SHALL register granted tags: a handshake in cycle t appears on cdb_tags/cdb_valid in cycle t+1 (latency 1).
REQ-015 SHALL drive cdb_tags lane = `PHYS_REG_SZ_R10K (invalid tag) and cdb_valid lane = 0 for every ungranted lane.
REQ-016 SHALL update rr_ptr to (index of last granted FU + 1) mod NUM_FU after any cycle with >=1 grant; unchanged with no grants.
REQ-017 SHALL, when squash is high in cycle t, drive all lanes invalid in t+1, deassert all fu_ready in t, and keep rr_ptr unchanged.
REQ-018 SHALL treat a request with fu_valid high and fu_tag == `PHYS_REG_SZ_R10K as valid (no special-casing); requesters must not issue it.
REQ-019 SHALL require (assertion) a requester to hold fu_valid and fu_tag stable until granted; violation flagged in simulation only.
REQ-020 SHALL grant all requesters in one cycle when popcount(fu_valid) <= `N.

Reset
REQ-021 SHALL, on reset assertion (any time, including mid-broadcast), immediately clear cdb_valid to 0, set cdb_tags to `PHYS_REG_SZ_R10K, rr_ptr to 0, starvation counters to 0.
REQ-022 SHALL hold fu_ready all 0 while reset is high.

Configuration
REQ-023 SHALL, with CDB_STARVE_GUARD_EN defined, keep a per-FU wait counter incremented each cycle fu_valid is high and not granted, cleared on grant or squash.
REQ-024 SHALL, with CDB_STARVE_GUARD_EN defined, place any FU whose counter >= STARVE_LIMIT on lane 0 ahead of round-robin order (lowest index if several), remaining lanes filled round-robin.
REQ-025 SHALL, without CDB_STARVE_GUARD_EN, contain no wait counters and use pure round-robin.

Structure
REQ-026 SHALL take PHYS_REG_IDX_BIG, `N, `PHYS_REG_SZ_R10K from the shared system-defs package; add CDB_PACKET (tag + valid) typedef there.
REQ-027 SHALL use one sub-module rr_pick_n: rotating-priority N-of-M selector (pointer in, grant vector + lane indices out), purely combinational.

Verification (NUM_FU=6, `N=2, STARVE_LIMIT=4)
REQ-028 SHALL cover: reset, fu_valid=6'b000101, tags {FU0=12, FU2=40} -> fu_ready=000101 same cycle; next cycle cdb_tags={12,40}, cdb_valid=11, rr_ptr=3.
REQ-029 SHALL cover: rr_ptr=3, fu_valid=111111 held -> grants {3,4}, then {5,0}, then {1,2}; rr_ptr 5,1,3.
REQ-030 SHALL cover: only FU4 valid tag 7 -> lane0=7, lane1 tag=`PHYS_REG_SZ_R10K, cdb_valid=01.
REQ-031 SHALL cover: squash with fu_valid=000011 -> fu_ready=0, next cycle cdb_valid=00, rr_ptr unchanged.
REQ-032 SHALL cover: reset asserted between clock edges with cdb_valid=11 -> cdb_valid=00 before next edge, rr_ptr=0.
REQ-033 SHALL cover (CDB_STARVE_GUARD_EN): FU5 denied 4 cycles by FU0-4 traffic -> 5th cycle FU5 granted on lane 0.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared system definitions for the CDB arbiter: tag width, lane count, invalid tag
// and the CDB_PACKET lane type.
`ifndef N
`define N 2
`endif
`ifndef PHYS_REG_SZ_R10K
`define PHYS_REG_SZ_R10K 64
`endif

package cdb_arbiter_pkg;

  localparam int PHYS_REG_IDX_BIG = 7;
  localparam int CDB_LANES        = `N;

  typedef logic [PHYS_REG_IDX_BIG-1:0] phys_tag_t;

  localparam phys_tag_t INVALID_TAG = PHYS_REG_IDX_BIG'(`PHYS_REG_SZ_R10K);

  typedef struct packed {
    phys_tag_t tag;
    logic      valid;
  } CDB_PACKET;

  // An invalid lane always carries the invalid tag so consumers never see a stale one.
  function automatic CDB_PACKET cdb_pkt(input phys_tag_t tag, input logic valid);
    CDB_PACKET p;
    p.valid = valid;
    p.tag   = valid ? tag : INVALID_TAG;
    return p;
  endfunction

endpackage

// File: rtl/cdb_arbiter_checker.sv
// cdb_arbiter_checker: simulation-only protocol checks on the requester side --
// an ungranted request must be held with a stable tag until it is granted.
module cdb_arbiter_checker
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU = 6
) (
  input logic                                 clock,
  input logic                                 reset,
  input logic                                 squash,
  input logic [NUM_FU-1:0]                    fu_valid,
  input logic [NUM_FU-1:0]                    fu_ready,
  input logic [NUM_FU-1:0][PHYS_REG_IDX_BIG-1:0] fu_tag
);

  // A squash releases requesters from their obligation to hold.
  for (genvar i = 0; i < NUM_FU; i++) begin : g_hold
    hold_until_granted : assert property (
      @(posedge clock) disable iff (reset)
      (fu_valid[i] && !fu_ready[i] && !squash) |=> (fu_valid[i] && (fu_tag[i] == $past(fu_tag[i])))
    );
  end

endmodule

// File: rtl/cdb_arbiter_rr_pick_n.sv
// rr_pick_n: combinational rotating-priority selector that picks up to LANES of
// NUM_REQ requests, searching from ptr and filling lanes in search order.
module rr_pick_n #(
  parameter int NUM_REQ = 6,
  parameter int LANES   = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [IDX_W-1:0]            ptr,
  output logic [NUM_REQ-1:0]          grant,
  output logic [LANES-1:0]            lane_vld,
  output logic [LANES-1:0][IDX_W-1:0] lane_idx
);

  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  logic [IDX_W:0] sum;
  logic [IDX_W:0] idx;
  logic [LW:0]    filled;

  // Walk all requesters once from ptr, wrapping at NUM_REQ, until the lanes are full.
  always_comb begin
    grant    = '0;
    lane_vld = '0;
    lane_idx = '0;
    filled   = '0;
    sum      = '0;
    idx      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sum = {1'b0, ptr} + (IDX_W+1)'(off);
      idx = (sum >= (IDX_W+1)'(NUM_REQ)) ? (sum - (IDX_W+1)'(NUM_REQ)) : sum;
      if (req[idx[IDX_W-1:0]] && (filled < (LW+1)'(LANES))) begin
        grant[idx[IDX_W-1:0]]    = 1'b1;
        lane_vld[filled[LW-1:0]] = 1'b1;
        lane_idx[filled[LW-1:0]] = idx[IDX_W-1:0];
        filled                   = filled + (LW+1)'(1);
      end else begin
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants up to `N completing functional units per cycle round-robin and
// broadcasts their tags one cycle later. Optional starvation guard: CDB_STARVE_GUARD_EN.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU       = 6,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic [NUM_FU-1:0]                       fu_valid,
  input  logic [NUM_FU-1:0][PHYS_REG_IDX_BIG-1:0] fu_tag,
  input  logic                                    squash,
  output logic [NUM_FU-1:0]                       fu_ready,
  output logic [CDB_LANES-1:0][PHYS_REG_IDX_BIG-1:0] cdb_tags,
  output logic [CDB_LANES-1:0]                    cdb_valid
);

  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  if ((NUM_FU < CDB_LANES) || (CDB_LANES < 2) || (STARVE_LIMIT < 1)) begin : g_cfg_err
    $error("cdb_arbiter: needs NUM_FU >= lanes >= 2 and STARVE_LIMIT >= 1");
  end

  logic [IDX_W-1:0]                rr_ptr;
  logic [IDX_W-1:0]                rr_ptr_nxt;
  logic [IDX_W-1:0]                last_idx;
  logic [NUM_FU-1:0]               pick_req;
  logic [NUM_FU-1:0]               pick_grant;
  logic [NUM_FU-1:0]               grant;
  logic [CDB_LANES-1:0]            pick_vld;
  logic [CDB_LANES-1:0]            lane_vld;
  logic [CDB_LANES-1:0][IDX_W-1:0] pick_idx;
  logic [CDB_LANES-1:0][IDX_W-1:0] lane_idx;
  CDB_PACKET [CDB_LANES-1:0]       cdb_q;
  CDB_PACKET [CDB_LANES-1:0]       cdb_d;

  rr_pick_n #(
    .NUM_REQ (NUM_FU),
    .LANES   (CDB_LANES),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req      (pick_req),
    .ptr      (rr_ptr),
    .grant    (pick_grant),
    .lane_vld (pick_vld),
    .lane_idx (pick_idx)
  );

`ifdef CDB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [NUM_FU-1:0][CNT_W-1:0] wait_cnt;
  logic                         starve_hit;
  logic [IDX_W-1:0]             starve_idx;
  logic [NUM_FU-1:0]            starve_oh;
  logic [NUM_FU-1:0]            drop_oh;

  // Lowest-index requester whose wait has reached STARVE_LIMIT.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (fu_valid[i] && (wait_cnt[i] >= CNT_W'(STARVE_LIMIT))) begin
        starve_hit = 1'b1;
        starve_idx = IDX_W'(i);
      end else begin
      end
    end
  end

  assign starve_oh = starve_hit ? (NUM_FU'(1) << starve_idx) : '0;
  assign pick_req  = fu_valid & ~starve_oh;

  // Starved FU takes lane 0; round-robin picks shift up and the overflow pick is dropped.
  always_comb begin
    drop_oh  = '0;
    lane_vld = pick_vld;
    lane_idx = pick_idx;
    if (starve_hit) begin
      lane_vld = {pick_vld[CDB_LANES-2:0], 1'b1};
      lane_idx = {pick_idx[CDB_LANES-2:0], starve_idx};
      if (pick_vld[CDB_LANES-1]) begin
        drop_oh = NUM_FU'(1) << pick_idx[CDB_LANES-1];
      end else begin
        drop_oh = '0;
      end
    end else begin
      lane_vld = pick_vld;
      lane_idx = pick_idx;
    end
  end

  assign grant = (pick_grant & ~drop_oh) | starve_oh;

  // Wait counters: count ungranted cycles, saturate at the limit, clear on grant or squash.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (squash || grant[i]) begin
          wait_cnt[i] <= '0;
        end else if (fu_valid[i] && (wait_cnt[i] < CNT_W'(STARVE_LIMIT))) begin
          wait_cnt[i] <= wait_cnt[i] + CNT_W'(1);
        end else begin
          wait_cnt[i] <= wait_cnt[i];
        end
      end
    end
  end
`else
  assign pick_req = fu_valid;
  assign lane_vld = pick_vld;
  assign lane_idx = pick_idx;
  assign grant    = pick_grant;
`endif

  assign fu_ready = (reset || squash) ? '0 : grant;

  // Pointer moves past the FU on the highest used lane; squash or no grant leaves it.
  always_comb begin
    last_idx   = rr_ptr;
    rr_ptr_nxt = rr_ptr;
    for (int l = 0; l < CDB_LANES; l++) begin
      if (lane_vld[l]) begin
        last_idx = lane_idx[l];
      end else begin
      end
    end
    if (squash || (lane_vld == '0)) begin
      rr_ptr_nxt = rr_ptr;
    end else if (last_idx == IDX_W'(NUM_FU - 1)) begin
      rr_ptr_nxt = '0;
    end else begin
      rr_ptr_nxt = last_idx + IDX_W'(1);
    end
  end

  // Next broadcast per lane; a squash empties every lane.
  always_comb begin
    cdb_d = '0;
    for (int l = 0; l < CDB_LANES; l++) begin
      cdb_d[l] = cdb_pkt(fu_tag[lane_idx[l]], lane_vld[l] && !squash);
    end
  end

  // Broadcast and pointer registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int l = 0; l < CDB_LANES; l++) begin
        cdb_q[l] <= cdb_pkt(INVALID_TAG, 1'b0);
      end
    end else begin
      rr_ptr <= rr_ptr_nxt;
      cdb_q  <= cdb_d;
    end
  end

  // Unpack the registered lanes onto the output ports.
  always_comb begin
    cdb_tags  = '0;
    cdb_valid = '0;
    for (int l = 0; l < CDB_LANES; l++) begin
      cdb_tags[l]  = cdb_q[l].tag;
      cdb_valid[l] = cdb_q[l].valid;
    end
  end

`ifndef SYNTHESIS
  cdb_arbiter_checker #(
    .NUM_FU (NUM_FU)
  ) u_chk (
    .clock    (clock),
    .reset    (reset),
    .squash   (squash),
    .fu_valid (fu_valid),
    .fu_ready (fu_ready),
    .fu_tag   (fu_tag)
  );
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios then random traffic,
// compared against a queue-based model of the grant rules.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NUM_FU       = 6;
  localparam int STARVE_LIMIT = 4;
  localparam int LANES        = CDB_LANES;
  localparam int BAD_TAG      = `PHYS_REG_SZ_R10K;

  logic clock = 1'b0;
  logic reset;
  logic squash;
  logic [NUM_FU-1:0]                       fu_valid;
  logic [NUM_FU-1:0][PHYS_REG_IDX_BIG-1:0] fu_tag;
  logic [NUM_FU-1:0]                       fu_ready;
  logic [LANES-1:0][PHYS_REG_IDX_BIG-1:0]  cdb_tags;
  logic [LANES-1:0]                        cdb_valid;

  always #5 clock = ~clock;

  cdb_arbiter #(
    .NUM_FU       (NUM_FU),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .fu_valid  (fu_valid),
    .fu_tag    (fu_tag),
    .squash    (squash),
    .fu_ready  (fu_ready),
    .cdb_tags  (cdb_tags),
    .cdb_valid (cdb_valid)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  int m_ptr;
  int m_cnt [NUM_FU];
  int m_tag [LANES];
  bit m_vld [LANES];
  int exp_lane [$];
  logic [NUM_FU-1:0] exp_grant;
  logic [NUM_FU-1:0] exp_ready;
  logic [NUM_FU-1:0] last_ready;
  logic [NUM_FU-1:0] hold;
  bit seen5;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  function automatic void model_reset();
    m_ptr = 0;
    for (int i = 0; i < NUM_FU; i++) m_cnt[i] = 0;
    for (int l = 0; l < LANES; l++) begin
      m_tag[l] = BAD_TAG;
      m_vld[l] = 1'b0;
    end
  endfunction

  // Lane list: optional starved FU first, then valid FUs in order ptr, ptr+1, ... (mod NUM_FU).
  function automatic void model_compute();
    int s;
    int i;
    s = -1;
    exp_lane.delete();
`ifdef CDB_STARVE_GUARD_EN
    for (int k = 0; k < NUM_FU; k++)
      if (s < 0 && fu_valid[k] && m_cnt[k] >= STARVE_LIMIT) s = k;
    if (s >= 0) exp_lane.push_back(s);
`endif
    for (int k = 0; k < NUM_FU; k++) begin
      i = (m_ptr + k) % NUM_FU;
      if (fu_valid[i] && i != s && exp_lane.size() < LANES) exp_lane.push_back(i);
    end
    exp_grant = '0;
    foreach (exp_lane[j]) exp_grant = exp_grant | (NUM_FU'(1) << exp_lane[j]);
    exp_ready = (reset || squash) ? '0 : exp_grant;
  endfunction

  function automatic void model_advance();
    if (reset) begin
      model_reset();
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (!squash && l < exp_lane.size()) begin
          m_vld[l] = 1'b1;
          m_tag[l] = int'(fu_tag[exp_lane[l]]);
        end else begin
          m_vld[l] = 1'b0;
          m_tag[l] = BAD_TAG;
        end
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (squash || exp_grant[i]) m_cnt[i] = 0;
        else if (fu_valid[i] && m_cnt[i] < STARVE_LIMIT) m_cnt[i]++;
      end
      if (!squash && exp_lane.size() > 0) m_ptr = (exp_lane[exp_lane.size()-1] + 1) % NUM_FU;
    end
  endfunction

  // Check one cycle mid-period, then cross the next rising edge.
  task automatic cycle(input string tag);
    logic [LANES-1:0] ev;
    #2;
    if (reset) model_reset();
    model_compute();
    last_ready = fu_ready;
    chk({tag, "/fu_ready"}, 64'(fu_ready), 64'(exp_ready));
    ev = '0;
    for (int l = 0; l < LANES; l++) begin
      ev[l] = m_vld[l];
      chk({tag, "/cdb_tag"}, 64'(cdb_tags[l]), 64'(m_tag[l]));
    end
    chk({tag, "/cdb_valid"}, 64'(cdb_valid), 64'(ev));
    chk({tag, "/rr_ptr"}, 64'(dut.rr_ptr), 64'(m_ptr));
    @(posedge clock);
    model_advance();
    #1;
  endtask

  initial begin
    reset = 1'b1; squash = 1'b0; fu_valid = '0; fu_tag = '0;
    model_reset();
    @(posedge clock); #1;

    // requests during reset must not be granted
    fu_valid = '1;
    cycle("reset");
    reset = 1'b0; fu_valid = '0;
    cycle("idle");

    // two sparse requesters, both granted, broadcast next cycle
    fu_valid = 6'b000101; fu_tag[0] = 7'd12; fu_tag[2] = 7'd40;
    cycle("two_req");
    chk("two_req_ready", 64'(last_ready), 64'(6'b000101));
    chk("two_req_lane0", 64'(cdb_tags[0]), 64'd12);
    chk("two_req_lane1", 64'(cdb_tags[1]), 64'd40);
    chk("two_req_valid", 64'(cdb_valid), 64'(2'b11));
    chk("two_req_ptr", 64'(dut.rr_ptr), 64'd3);

    // all requesters held: rotation 3,4 / 5,0 / 1,2
    fu_valid = 6'b111111;
    for (int i = 0; i < NUM_FU; i++) fu_tag[i] = 7'(20 + i);
    cycle("all_a");
    chk("all_a_ready", 64'(last_ready), 64'(6'b011000));
    chk("all_a_ptr", 64'(dut.rr_ptr), 64'd5);
    cycle("all_b");
    chk("all_b_ready", 64'(last_ready), 64'(6'b100001));
    chk("all_b_ptr", 64'(dut.rr_ptr), 64'd1);
    cycle("all_c");
    chk("all_c_ready", 64'(last_ready), 64'(6'b000110));
    chk("all_c_ptr", 64'(dut.rr_ptr), 64'd3);
    squash = 1'b1;
    cycle("all_squash");
    chk("all_squash_ready", 64'(last_ready), 64'd0);
    squash = 1'b0;

    // single requester: lane 1 idle with the invalid tag
    fu_valid = 6'b010000; fu_tag[4] = 7'd7;
    cycle("single");
    chk("single_lane0", 64'(cdb_tags[0]), 64'd7);
    chk("single_lane1", 64'(cdb_tags[1]), 64'(BAD_TAG));
    chk("single_valid", 64'(cdb_valid), 64'(2'b01));

    // squash: no grant, empty lanes, pointer held
    fu_valid = 6'b000011; squash = 1'b1;
    cycle("squash");
    chk("squash_ready", 64'(last_ready), 64'd0);
    chk("squash_valid", 64'(cdb_valid), 64'(2'b00));
    chk("squash_ptr", 64'(dut.rr_ptr), 64'd5);
    squash = 1'b0;

    // the invalid-tag value is still an ordinary request
    fu_valid = 6'b000010; fu_tag[1] = 7'(BAD_TAG);
    cycle("badtag");
    chk("badtag_valid", 64'(cdb_valid), 64'(2'b01));
    chk("badtag_lane0", 64'(cdb_tags[0]), 64'(BAD_TAG));

    // reset pulse between edges while both lanes are live
    fu_valid = 6'b001001; fu_tag[0] = 7'd9; fu_tag[3] = 7'd33;
    cycle("pre_rst");
    chk("pre_rst_valid", 64'(cdb_valid), 64'(2'b11));
    chk("pre_rst_lane0", 64'(cdb_tags[0]), 64'd33);
    fu_valid = '0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(cdb_valid), 64'(2'b00));
    chk("async_rst_tag0", 64'(cdb_tags[0]), 64'(BAD_TAG));
    chk("async_rst_tag1", 64'(cdb_tags[1]), 64'(BAD_TAG));
    chk("async_rst_ptr", 64'(dut.rr_ptr), 64'd0);
    chk("async_rst_ready", 64'(fu_ready), 64'd0);
    #1 reset = 1'b0;
    model_reset();
    cycle("post_rst");

`ifdef CDB_STARVE_GUARD_EN
    // FU5 competing with FU0-4 must be served within a bounded number of cycles
    seen5 = 1'b0;
    fu_valid = 6'b111111;
    for (int c = 0; c < STARVE_LIMIT + 1; c++) begin
      cycle("starve");
      seen5 = seen5 | last_ready[5];
    end
    chk("starve_fu5_served", 64'(seen5), 64'd1);
    squash = 1'b1;
    cycle("starve_flush");
    squash = 1'b0;
`endif

    // random traffic; ungranted requests are held with a stable tag
    hold = '0;
    for (int c = 0; c < 400; c++) begin
      reset  = ($urandom_range(0, 99) == 0);
      squash = !reset && ($urandom_range(0, 99) < 6);
      for (int i = 0; i < NUM_FU; i++) begin
        if (!hold[i]) begin
          fu_valid[i] = ($urandom_range(0, 99) < 55);
          fu_tag[i]   = 7'($urandom_range(0, BAD_TAG - 1));
        end
      end
      cycle("rand");
      hold = (reset || squash) ? '0 : (fu_valid & ~exp_ready);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
